deserializer: RTL
=================

Name: deserializer

Overview:
- Serial-to-parallel receiver; the counterpart of the existing serializer, using the same bit order and word width.
- Collects FETCH_WIDTH-bit words from a one-bit debug/config stream, LSB first.
- Presents each word on a valid/ready output port that drives an SRAM interface write path (wen/wdata_in).
- Double-buffered: the next word shifts in while the previous one waits for the consumer.

Parameters:
- FETCH_WIDTH, 16, bits per word; must be >= 2.
- COUNT_WIDTH, 12, width of the accepted-word counter (matches the bank address width).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable; low flushes all state.
- serial_data  in  1  serial bit, sampled when en && in_valid.
- in_valid  in  1  serial_data holds a valid bit this cycle.
- parallel_data  out  FETCH_WIDTH  assembled word; bit 0 is the first bit received.
- out_valid  out  1  parallel_data holds an unconsumed word.
- receiver_rdy  in  1  consumer takes the word this cycle when out_valid is high.
- word_count  out  COUNT_WIDTH  number of words loaded into the output register; wraps modulo 2^COUNT_WIDTH.
- overrun  out  1  sticky: a completed word was dropped.
- parity_err  out  1  sticky parity error; tied 0 unless the macro below is defined.

Behaviour:
- Reset (rst_n low, asynchronous), all zero: shift register, bit counter, parallel_data, out_valid, word_count, overrun, parity_err.
- Bit capture: on an edge where en && in_valid, serial_data is written to shift bit [bit_cnt] and bit_cnt increments.
  - Cycles with in_valid low are idle. State holds, with no timeout.
- Word complete: the edge that samples bit FETCH_WIDTH-1 is the completion edge.
  - The full word (the new bit included) is a candidate for the output register.
  - bit_cnt returns to 0.
  - Latency: out_valid and parallel_data update at the completion edge itself and are visible in the following cycle.
- Output register:
  - States: EMPTY (out_valid=0) and FULL (out_valid=1). A dequeue happens when out_valid && receiver_rdy at an edge.
  - EMPTY + completion -> load the word, FULL, word_count += 1.
  - FULL + dequeue, no completion -> EMPTY. parallel_data holds its last value.
  - FULL + dequeue + completion on the same edge -> load the new word, stay FULL, word_count += 1. No overrun.
  - FULL + completion, no dequeue -> drop the new word and keep the old one. overrun sets to 1; word_count unchanged.
  - receiver_rdy while EMPTY has no effect.
- parallel_data stays stable while out_valid is high until the dequeue edge.
- en low (synchronous, any edge), clears:
  - bit_cnt and the partial word
  - out_valid, so a pending word is discarded
  - word_count, overrun and parity_err
  - parallel_data holds its value.
- Re-asserting en starts a fresh word at bit 0. Bits presented in the same cycle that en is low are ignored.
- word_count wraps from 2^COUNT_WIDTH-1 to 0 with no flag.

Optional Feature:
- Macro: DESERIALIZER_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit, so each frame is FETCH_WIDTH+1 valid bits.
  - The completion edge becomes the edge that samples the parity bit.
  - If XOR of the data bits != parity bit, parity_err sets (sticky) and the word is still delivered through the normal load/drop rules.
  - bit_cnt counts 0..FETCH_WIDTH.
- Not defined: frames are FETCH_WIDTH bits and parity_err is constant 0.

Test Plan:
- Single word: reset, then en=1 and in_valid=1 for 16 cycles with bits of 16'hA5C3 LSB first, receiver_rdy=0.
  - out_valid rises in the cycle after the 16th bit; parallel_data=16'hA5C3; word_count=1; overrun=0.
- Gapped input: same word, with in_valid low on every other cycle.
  - Identical result; out_valid rises only after the 16th valid bit.
- Back-to-back with a simultaneous event: stream 16'h1234 then 16'hBEEF continuously. Pulse receiver_rdy exactly at the completion edge of 16'hBEEF.
  - parallel_data goes 1234 -> BEEF; out_valid never drops; word_count=2; overrun=0.
- Overrun: stream 16'h0001, 16'h0002, 16'h0003 with receiver_rdy=0.
  - parallel_data stays 16'h0001; overrun=1 after the 2nd word completes; word_count=1.
- Flush: send 7 bits, drop en for 1 cycle, re-enable, then send 16'hFFFF.
  - Result is 16'hFFFF, not corrupted by the partial bits; word_count=1.
  - Asserting rst_n low mid-word zeroes every output immediately, without waiting for a clock edge.
- Loopback, plus parity with DESERIALIZER_PARITY_EN defined:
  - Loopback: serializer + SRAM interface stream 4096 random words into the deserializer, receiver_rdy=1. All words match in order; word_count wraps to 0.
  - Parity, macro defined: 16'h0003 with parity bit 1 -> parity_err=1, word still delivered.
  - Parity, macro defined: 16'h0003 with parity bit 0 -> parity_err stays 0.

Source files
------------

// File: rtl/deserializer.sv
// deserializer: LSB-first serial-to-parallel receiver with a double-buffered valid/ready output.
// Define DESERIALIZER_PARITY_EN to expect an even-parity bit after each word and flag mismatches.
module deserializer #(
   parameter int FETCH_WIDTH = 16,
   parameter int COUNT_WIDTH = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   serial_data,
   input  logic                   in_valid,
   output logic [FETCH_WIDTH-1:0] parallel_data,
   output logic                   out_valid,
   input  logic                   receiver_rdy,
   output logic [COUNT_WIDTH-1:0] word_count,
   output logic                   overrun,
   output logic                   parity_err
);
`ifdef DESERIALIZER_PARITY_EN
   localparam int FRAME = FETCH_WIDTH + 1;
`else
   localparam int FRAME = FETCH_WIDTH;
`endif
   localparam int BW = $clog2(FRAME);
   localparam logic [BW-1:0] LAST = BW'(FRAME - 1);
   logic [FETCH_WIDTH-1:0] shift_q, shift_d, data_q, data_d, word, sel;
   logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   valid_q, valid_d, ovr_q, ovr_d, perr_q, perr_d, par_q, par_d;
   logic                   cap, done, deq, load;
   always_comb begin
      cap = en && in_valid;
      done = cap && bit_cnt_q == LAST;
      deq = valid_q && receiver_rdy;
      load = done && (!valid_q || deq);
      // the parity bit position shifts past the word, so sel is zero and the word is untouched
      sel = FETCH_WIDTH'(1) << bit_cnt_q;
      word = serial_data ? (shift_q | sel) : (shift_q & ~sel);
      shift_d = cap ? (done ? '0 : word) : shift_q;
      bit_cnt_d = cap ? (done ? '0 : bit_cnt_q + BW'(1)) : bit_cnt_q;
      valid_d = load || (valid_q && !deq);
      data_d = load ? word : data_q;
      count_d = count_q + COUNT_WIDTH'(load);
      ovr_d = ovr_q || (done && valid_q && !deq);
`ifdef DESERIALIZER_PARITY_EN
      par_d = cap ? (done ? 1'b0 : par_q ^ serial_data) : par_q;
      perr_d = perr_q || (done && par_q != serial_data);
`else
      par_d = 1'b0;
      perr_d = 1'b0;
`endif
      if (!en) begin
         shift_d = '0;
         bit_cnt_d = '0;
         valid_d = 1'b0;
         count_d = '0;
         ovr_d = 1'b0;
         par_d = 1'b0;
         perr_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         bit_cnt_q <= '0;
         data_q <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
         ovr_q <= 1'b0;
         par_q <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         data_q <= data_d;
         valid_q <= valid_d;
         count_q <= count_d;
         ovr_q <= ovr_d;
         par_q <= par_d;
         perr_q <= perr_d;
      end
   end
   assign parallel_data = data_q;
   assign out_valid = valid_q;
   assign word_count = count_q;
   assign overrun = ovr_q;
   assign parity_err = perr_q;
endmodule
